// File: rtl/tv80_busbridge.sv
// Bridges TV80 CPU bus cycles onto a req/ack fabric, stretching the CPU with wait_n.
// Define TV80_BUSTMO_EN to add a bus-request timeout that completes a stalled access.
module tv80_busbridge #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  IM2_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        tmo_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

  state_t state;
  logic   rw, mem_acc, io_acc, int_ack, access;

  assign rw      = ~rd_n | ~wr_n;
  assign mem_acc = ~mreq_n & rfsh_n & rw;
  assign io_acc  = ~iorq_n & m1_n & rw;
  assign int_ack = ~iorq_n & ~m1_n;
  assign access  = mem_acc | io_acc;

  // Stall the CPU from the detect cycle on, so it never samples stale data.
  assign wait_n = ~(reset_n & (((state == StIdle) & access) | (state == StReq)));

`ifdef TV80_BUSTMO_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
      di        <= 8'h00;
`ifdef TV80_BUSTMO_EN
      tmo_cnt   <= 16'h0000;
      tmo_err   <= 1'b0;
`endif
    end else begin
`ifdef TV80_BUSTMO_EN
      tmo_err <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (access) begin
            state     <= StReq;
            bus_req   <= 1'b1;
            bus_addr  <= A;
            bus_wdata <= dout;
            bus_we    <= ~wr_n;
            bus_io    <= io_acc;
`ifdef TV80_BUSTMO_EN
            tmo_cnt   <= 16'h0000;
`endif
          end else if (int_ack) begin
            di <= IM2_VECTOR;
          end
        end
        StReq: begin
          // Ack wins over a timeout landing on the same edge.
          if (bus_ack) begin
            state   <= StDone;
            bus_req <= 1'b0;
            if (!bus_we) di <= bus_rdata;
          end
`ifdef TV80_BUSTMO_EN
          else if (tmo_hit) begin
            state   <= StDone;
            bus_req <= 1'b0;
            di      <= 8'hFF;
            tmo_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        StDone: begin
          if (rd_n && wr_n) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tv80_busbridge.sv
// Randomised transaction-level bench for tv80_busbridge; expectations come from
// per-access rules (wait/request cycle counts, latched fields, expected di).
module tb_tv80_busbridge;

  localparam logic [7:0] Im2 = 8'hC7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic [7:0]  di;
  logic        wait_n, bus_req, bus_we, bus_io, tmo_err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_di = 8'h00;

  tv80_busbridge #(
    .TIMEOUT   (8),
    .IM2_VECTOR(Im2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .rfsh_n   (rfsh_n),
    .A        (A),
    .dout     (dout),
    .di       (di),
    .wait_n   (wait_n),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_io   (bus_io),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic strobes_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One CPU access: fabric acks in REQ cycle ack_dly+1 (never if ack_dly < 0), strobes held
  // for hold extra cycles after completion. Returns observed cycle counts and latched fields.
  task automatic cpu_access(input bit io, input bit wr, input logic [15:0] addr,
                            input logic [7:0] wdata, input int ack_dly, input logic [7:0] rdata,
                            input int hold, output int waits, output int reqs, output int tmos,
                            output logic [15:0] c_addr, output logic c_we, output logic c_io,
                            output logic [7:0] c_wdata, output bit hung);
    int rc;
    bit seen;
    waits = 0; reqs = 0; tmos = 0; rc = 0; seen = 1'b0; hung = 1'b1;
    c_addr = 'x; c_we = 1'bx; c_io = 1'bx; c_wdata = 'x;
    A = addr; dout = wdata;
    if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    if (!io && !wr) m1_n = 1'($urandom);
    for (int i = 0; i < 200 && hung; i++) begin
      if (bus_req) begin
        rc++;
        if (!seen) begin
          seen = 1'b1; c_addr = bus_addr; c_we = bus_we; c_io = bus_io; c_wdata = bus_wdata;
        end
      end
      bus_ack   = bus_req && (rc == ack_dly + 1);
      bus_rdata = bus_ack ? rdata : 8'($urandom);
      @(negedge clk);
      if (!wait_n) waits++;
      if (bus_req) reqs++;
      if (tmo_err) tmos++;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (seen && !bus_req) hung = 1'b0;
    end
    // Stray acks while the access is finishing must be ignored.
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) strobes_idle();
      bus_ack   = 1'($urandom);
      bus_rdata = 8'($urandom);
      @(negedge clk);
      if (!wait_n) waits++;
      if (bus_req) reqs++;
      if (tmo_err) tmos++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; A = 16'hBEEF; dout = 8'h77;
    repeat (2) @(negedge clk);
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n got %b exp 1", wait_n); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
    checks++; if ({bus_we, bus_io} !== 2'b00) begin errors++; $display("FAIL rst_we_io got %b exp 00", {bus_we, bus_io}); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("FAIL rst_bus_addr got %h exp 0000", bus_addr); end
    checks++; if (bus_wdata !== 8'h00) begin errors++; $display("FAIL rst_bus_wdata got %h exp 00", bus_wdata); end
    checks++; if (di !== 8'h00) begin errors++; $display("FAIL rst_di got %h exp 00", di); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL rst_tmo_err got %b exp 0", tmo_err); end
    strobes_idle();
    @(posedge clk); #1;
    reset_n = 1'b1; exp_di = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int w, r, t; logic [15:0] ca; logic cw, ci; logic [7:0] cd; bit hung;
    cpu_access(1'b0, 1'b0, 16'h1234, 8'h00, 2, 8'hA5, 0, w, r, t, ca, cw, ci, cd, hung);
    exp_di = 8'hA5;
    checks++; if (hung) begin errors++; $display("FAIL mrd_hung got 1 exp 0"); end
    checks++; if (ca !== 16'h1234) begin errors++; $display("FAIL mrd_addr got %h exp 1234", ca); end
    checks++; if ({cw, ci} !== 2'b00) begin errors++; $display("FAIL mrd_we_io got %b exp 00", {cw, ci}); end
    checks++; if (w !== 4) begin errors++; $display("FAIL mrd_wait_cycles got %0d exp 4", w); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL mrd_di got %h exp %h", di, exp_di); end
    cpu_access(1'b1, 1'b1, 16'h00FE, 8'h3C, 0, 8'h11, 0, w, r, t, ca, cw, ci, cd, hung);
    checks++; if ({cw, ci} !== 2'b11) begin errors++; $display("FAIL iowr_we_io got %b exp 11", {cw, ci}); end
    checks++; if (cd !== 8'h3C) begin errors++; $display("FAIL iowr_wdata got %h exp 3c", cd); end
    checks++; if (ca !== 16'h00FE) begin errors++; $display("FAIL iowr_addr got %h exp 00fe", ca); end
    checks++; if (r !== 1) begin errors++; $display("FAIL iowr_req_cycles got %0d exp 1", r); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL iowr_di got %h exp %h", di, exp_di); end
  endtask

  task automatic test_refresh_inta();
    int w, r;
    w = 0; r = 0;
    mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; A = 16'h007F;
    repeat (3) begin
      bus_ack = 1'($urandom); bus_rdata = 8'($urandom);
      @(negedge clk); if (!wait_n) w++; if (bus_req) r++;
      @(posedge clk); #1;
    end
    strobes_idle(); bus_ack = 1'b0;
    m1_n = 1'b0; iorq_n = 1'b0;
    repeat (2) begin
      @(negedge clk); if (!wait_n) w++; if (bus_req) r++;
      @(posedge clk); #1;
    end
    strobes_idle();
    exp_di = Im2;
    checks++; if (w !== 0) begin errors++; $display("FAIL rfsh_inta_wait_cycles got %0d exp 0", w); end
    checks++; if (r !== 0) begin errors++; $display("FAIL rfsh_inta_req_cycles got %0d exp 0", r); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL inta_di got %h exp %h", di, exp_di); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_req();
    int w, r, t; logic [15:0] ca; logic cw, ci; logic [7:0] cd, rd; bit hung;
    A = 16'h4242; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rreq_setup got %b exp 1", bus_req); end
    @(negedge clk); #2;
    reset_n = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rreq_bus_req got %b exp 0", bus_req); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rreq_wait_n got %b exp 1", wait_n); end
    strobes_idle();
    @(posedge clk); #1;
    reset_n = 1'b1; exp_di = 8'h00;
    bus_ack = 1'b1; bus_rdata = 8'h99;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL late_ack_req got %b exp 0", bus_req); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL late_ack_di got %h exp %h", di, exp_di); end
    rd = 8'($urandom);
    cpu_access(1'b0, 1'b0, 16'h5A5A, 8'h00, 1, rd, 0, w, r, t, ca, cw, ci, cd, hung);
    exp_di = rd;
    checks++; if (w !== 3 || r !== 2) begin errors++; $display("FAIL post_rst_cycles got w%0d r%0d exp w3 r2", w, r); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL post_rst_di got %h exp %h", di, exp_di); end
  endtask

  task automatic test_random();
    int w, r, t, dly, hold; logic [15:0] ca, ad; logic cw, ci, io, wr; logic [7:0] cd, wd, rd;
    bit hung;
    for (int n = 0; n < 40; n++) begin
      io = 1'($urandom); wr = 1'($urandom); ad = 16'($urandom); wd = 8'($urandom);
      rd = 8'($urandom); dly = int'($urandom_range(5, 0)); hold = int'($urandom_range(2, 0));
      cpu_access(io, wr, ad, wd, dly, rd, hold, w, r, t, ca, cw, ci, cd, hung);
      if (!wr) exp_di = rd;
      checks++; if (hung) begin errors++; $display("FAIL rnd%0d_hung got 1 exp 0", n); end
      checks++; if ({ca, cw, ci} !== {ad, wr, io}) begin
        errors++; $display("FAIL rnd%0d_latch got %h/%b/%b exp %h/%b/%b", n, ca, cw, ci, ad, wr, io);
      end
      if (wr) begin
        checks++; if (cd !== wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, cd, wd); end
      end
      checks++; if (w !== dly + 2 || r !== dly + 1) begin
        errors++; $display("FAIL rnd%0d_cycles got w%0d r%0d exp w%0d r%0d", n, w, r, dly + 2, dly + 1);
      end
      checks++; if (t !== 0) begin errors++; $display("FAIL rnd%0d_tmo got %0d exp 0", n, t); end
      checks++; if (di !== exp_di) begin errors++; $display("FAIL rnd%0d_di got %h exp %h", n, di, exp_di); end
    end
  endtask

  task automatic test_back_to_back();
    int w, r, t, dly; logic [15:0] ca; logic cw, ci; logic [7:0] cd, rd; bit hung;
    for (int n = 0; n < 3; n++) begin
      dly = int'($urandom_range(3, 0)); rd = 8'($urandom);
      cpu_access(1'b0, 1'b0, 16'($urandom), 8'h00, dly, rd, 2, w, r, t, ca, cw, ci, cd, hung);
      exp_di = rd;
      checks++; if (w !== dly + 2 || r !== dly + 1) begin
        errors++; $display("FAIL b2b%0d_cycles got w%0d r%0d exp w%0d r%0d", n, w, r, dly + 2, dly + 1);
      end
      checks++; if (di !== exp_di) begin errors++; $display("FAIL b2b%0d_di got %h exp %h", n, di, exp_di); end
    end
  endtask

  task automatic test_timeout();
    int w, r, t; logic [15:0] ca; logic cw, ci; logic [7:0] cd, rd; bit hung;
    rd = 8'($urandom);
`ifdef TV80_BUSTMO_EN
    cpu_access(1'b0, 1'b0, 16'h0100, 8'h00, -1, rd, 1, w, r, t, ca, cw, ci, cd, hung);
    exp_di = 8'hFF;
    checks++; if (hung || r !== 8 || w !== 9) begin
      errors++; $display("FAIL tmo_cycles got h%0d w%0d r%0d exp h0 w9 r8", hung, w, r);
    end
    checks++; if (t !== 1) begin errors++; $display("FAIL tmo_pulse got %0d exp 1", t); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL tmo_di got %h exp %h", di, exp_di); end
    cpu_access(1'b0, 1'b0, 16'h0200, 8'h00, 7, rd, 0, w, r, t, ca, cw, ci, cd, hung);
    exp_di = rd;
    checks++; if (t !== 0 || r !== 8) begin errors++; $display("FAIL ack_vs_tmo got t%0d r%0d exp t0 r8", t, r); end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL ack_vs_tmo_di got %h exp %h", di, exp_di); end
`else
    cpu_access(1'b1, 1'b0, 16'h0300, 8'h00, 30, rd, 0, w, r, t, ca, cw, ci, cd, hung);
    exp_di = rd;
    checks++; if (hung || r !== 31 || t !== 0) begin
      errors++; $display("FAIL long_wait got h%0d r%0d t%0d exp h0 r31 t0", hung, r, t);
    end
    checks++; if (di !== exp_di) begin errors++; $display("FAIL long_wait_di got %h exp %h", di, exp_di); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_refresh_inta();
    test_reset_in_req();
    test_random();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
